// File: rtl/fpu_op_sequencer_if.sv
// Request/response bundle between the issue logic, the FPU op sequencer and the result consumer.
interface fpu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_gr;
    logic        out_ls;
    logic        out_eq;
    logic        out_err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z, out_gr, out_ls, out_eq, out_err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z, out_gr, out_ls, out_eq, out_err
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Single-slot FPU sequencer: accepts one op, pulses the unit start, waits for done
// (or times out), then holds the captured response until the consumer takes it.
module fpu_op_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fpu_op_sequencer_if.slave         bus,
    output logic [31:0]               fu_a_o,
    output logic [31:0]               fu_b_o,
    output logic [4:0]                fu_start_o,
    input  logic [4:0]                fu_done_i,
    output logic [2:0]                fu_sel_o,
    input  logic [31:0]               j_z_i,
    input  logic                      j_gr_i,
    input  logic                      j_ls_i,
    input  logic                      j_eq_i
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    SEL_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        state_q;
    logic [2:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   fu_a_q;
    logic [31:0]   fu_b_q;
    logic [4:0]    fu_start_q;
    logic [2:0]    fu_sel_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [31:0]   out_z_q;
    logic          out_gr_q;
    logic          out_ls_q;
    logic          out_eq_q;
    logic          out_err_q;

    function automatic logic [4:0] op_onehot(input logic [2:0] op);
        return 5'b00001 << op;
    endfunction

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            cnt_q       <= '0;
            fu_a_q      <= 32'd0;
            fu_b_q      <= 32'd0;
            fu_start_q  <= 5'd0;
            fu_sel_q    <= SEL_NONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_z_q     <= 32'd0;
            out_gr_q    <= 1'b0;
            out_ls_q    <= 1'b0;
            out_eq_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            fu_start_q <= 5'd0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.in_op;
                        fu_a_q     <= bus.in_a;
                        fu_b_q     <= bus.in_b;
                        in_ready_q <= 1'b0;
                        if (bus.in_op <= 3'd4) begin
                            state_q    <= ST_LAUNCH;
                            fu_start_q <= op_onehot(bus.in_op);
                        end else begin
                            // Illegal opcode: answer with an error, no unit is started.
                            state_q     <= ST_RESP;
                            out_valid_q <= 1'b1;
                            out_z_q     <= 32'd0;
                            out_gr_q    <= 1'b0;
                            out_ls_q    <= 1'b0;
                            out_eq_q    <= 1'b0;
                            out_err_q   <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state_q  <= ST_WAIT;
                    cnt_q    <= '0;
                    fu_sel_q <= op_q;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Done has priority over a coincident timeout.
                    if (fu_done_i[op_q]) begin
                        state_q     <= ST_RESP;
                        fu_sel_q    <= SEL_NONE;
                        out_valid_q <= 1'b1;
                        out_z_q     <= j_z_i;
                        out_gr_q    <= j_gr_i;
                        out_ls_q    <= j_ls_i;
                        out_eq_q    <= j_eq_i;
                        out_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RESP;
                        fu_sel_q    <= SEL_NONE;
                        out_valid_q <= 1'b1;
                        out_z_q     <= 32'd0;
                        out_gr_q    <= 1'b0;
                        out_ls_q    <= 1'b0;
                        out_eq_q    <= 1'b0;
                        out_err_q   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    fu_sel_q    <= SEL_NONE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fu_a_o        = fu_a_q;
    assign fu_b_o        = fu_b_q;
    assign fu_start_o    = fu_start_q;
    assign fu_sel_o      = fu_sel_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_z     = out_z_q;
    assign bus.out_gr    = out_gr_q;
    assign bus.out_ls    = out_ls_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Single-slot controller that sequences the floating-point ALU. Accepts one operation at a time over a valid/ready handshake, registers the operands, pulses the start of the selected functional unit, and drives the result-select code to the result jointer. It waits for the unit's done, handles illegal opcodes and hung units, and holds the captured result until the consumer takes it. Sits between the instruction/issue logic and the add/sub/mul/div/compare units plus result mux.

## Interface
- `TIMEOUT`, 64: max WAIT cycles before abort (≥2).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready` at an edge.
- `in_op` in 3: 0 add, 1 sub, 2 mul, 3 div, 4 compare, 5–7 illegal.
- `in_a`, `in_b` in 32: IEEE-754 single operands.
- `fu_a`, `fu_b` out 32: registered operands to all units.
- `fu_start` out 5: one-hot start pulse, bit = opcode.
- `fu_done` in 5: per-unit done, bit = opcode; level or pulse.
- `fu_sel` out 3: select code to the result jointer.
- `j_z` in 32; `j_gr`, `j_ls`, `j_eq` in 1: jointer outputs.
- `out_valid` out 1; `out_ready` in 1: response handshake.
- `out_z` out 32; `out_gr`, `out_ls`, `out_eq`, `out_err` out 1: captured response.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: `in_ready`=1, `fu_sel`=3'b111 (jointer outputs zero). On accept, register `in_op`, `in_a`, `in_b`.
  - Legal op goes to LAUNCH.
  - Illegal op goes to RESP with `out_err`=1 and `out_z`/flags=0. No start pulse.
- LAUNCH (1 cycle): `fu_start[op]`=1. Clear the wait counter. Go to WAIT.
- WAIT: `fu_sel`=op. Counter increments every cycle.
  - If `fu_done[op]`=1: capture `j_z`, `j_gr`, `j_ls`, `j_eq` into the outputs, set `out_err`=0, go to RESP.
  - Otherwise, if counter = `TIMEOUT`-1: set `out_err`=1, `out_z`/flags=0, go to RESP.
  - Done wins if it coincides with the timeout cycle.
- `fu_done` bits of other units are ignored. `fu_done` is ignored outside WAIT.
- RESP: `out_valid`=1 and all outputs stable until `out_ready`=1. Then go to IDLE. `in_ready`=0 in LAUNCH, WAIT, RESP; there is no accept in the same cycle as a RESP handoff.
- Compare results are carried only on the flags (`out_z`=0). Arithmetic results are carried only on `out_z` (flags=0). Both follow from the jointer behaviour and are captured as-is.
- `fu_a`/`fu_b` hold their last value until the next accept.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE. `in_ready`=1 after reset. `out_valid`=0, `out_z`=0, flags=0, `out_err`=0, `fu_start`=0, `fu_sel`=3'b111, `fu_a`=`fu_b`=0, counter=0.
- Reset mid-operation aborts immediately. No response is produced, and the unit is not notified.
- Accept at edge 0 → `fu_start` high during cycle 1 → WAIT from cycle 2.
- `fu_done` sampled high at edge k gives `out_valid` from cycle k (registered), so latency = unit latency + 2 cycles minimum.
- Illegal op: `out_valid` high the cycle after accept.
- Timeout: `out_valid` rises `TIMEOUT`+1 cycles after LAUNCH.
- Throughput: at most one op per (unit latency + 3) cycles with `out_ready` tied high.

## Test plan
- Add 1.5 + 2.25 (a=0x3FC00000, b=0x40100000), `fu_done[0]` 3 cycles after start, `j_z`=0x40700000 → `fu_start`=5'b00001 for one cycle; `out_z`=0x40700000, `out_err`=0, flags 0.
- Compare 2.0 vs 1.0, `fu_done[4]` in first WAIT cycle, `j_gr`=1 → `out_gr`=1, `out_ls`=`out_eq`=0, `out_z`=0; `fu_sel`=4 during WAIT.
- `in_op`=6 → no `fu_start` bit; `out_valid` next cycle with `out_err`=1, `out_z`=0.
- Div with `fu_done` never asserted, `TIMEOUT`=8 → `out_err`=1 exactly 9 cycles after `fu_start[3]`. Also a spurious `fu_done[0]` during the wait is ignored.
- Back-pressure: `out_ready`=0 for 5 cycles on a mul result 0x40C00000 → outputs stable, `in_valid` held high is not accepted, accept occurs one cycle after the RESP handoff.
- `rst_n`=0 during WAIT → next cycle IDLE, `in_ready`=1, `out_valid`=0, `fu_sel`=7; a later `fu_done` is ignored.
